nv_nvdla_cdma_rd_arb: RTL and testbench



---
 rtl/nv_nvdla_cdma_rd_arb.sv | 194 +++++++++++++++++++
 tb/tb_nv_nvdla_cdma_rd_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_cdma_rd_arb.sv
// -----------------------------------------------------------------------------
// nv_nvdla_cdma_rd_arb
//
// Weighted arbiter that shares the CDMA read-request channel to the DMA engine
// between the feature-data (dat), weight (wt) and weight-mask-bit (wmb)
// fetch units. The weight group (wt + wmb) gets Qw grants for every dat
// grant; inside the weight group wt gets Qm grants for every wmb grant.
// The winning request is captured in a registered output stage, so a new
// grant can be issued every cycle while the DMA keeps accepting.
//
// Parameters:
//   PW                 payload width of each read request (address + size)
//
// Ports:
//   nvdla_core_clk     core clock
//   nvdla_core_rst     synchronous active-high reset
//   reg2dp_arb_weight  weight-group quota minus 1
//   reg2dp_arb_wmb     wt grants before a wmb grant, minus 1
//   dat_req_*          feature-data request (valid/ready/pd)
//   wt_req_*           weight request (valid/ready/pd)
//   wmb_req_*          weight-mask-bit request (valid/ready/pd)
//   dma_rd_req_*       request to DMA, pd = {src_id[1:0], payload}
//                      (src_id 0 = dat, 1 = wt, 2 = wmb)
//   arb_idle           no pending request at any input and none held
//   perf_*_cnt         per-source grant counters
//
// Optional feature: define NVDLA_CDMA_RD_ARB_PERF_EN to build the saturating
// perf_*_cnt grant counters; otherwise they are tied to zero.
// -----------------------------------------------------------------------------
module nv_nvdla_cdma_rd_arb #(
  parameter int PW = 79
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic [3:0]    reg2dp_arb_weight,
  input  logic [3:0]    reg2dp_arb_wmb,
  input  logic          dat_req_valid,
  output logic          dat_req_ready,
  input  logic [PW-1:0] dat_req_pd,
  input  logic          wt_req_valid,
  output logic          wt_req_ready,
  input  logic [PW-1:0] wt_req_pd,
  input  logic          wmb_req_valid,
  output logic          wmb_req_ready,
  input  logic [PW-1:0] wmb_req_pd,
  output logic          dma_rd_req_valid,
  input  logic          dma_rd_req_ready,
  output logic [PW+1:0] dma_rd_req_pd,
  output logic          arb_idle,
  output logic [31:0]   perf_dat_cnt,
  output logic [31:0]   perf_wt_cnt,
  output logic [31:0]   perf_wmb_cnt
);

  localparam logic [1:0] SRC_DAT = 2'd0;
  localparam logic [1:0] SRC_WT  = 2'd1;
  localparam logic [1:0] SRC_WMB = 2'd2;
  localparam logic [4:0] CNT_MAX = 5'd16;

  logic          out_valid;
  logic [PW+1:0] out_pd;
  logic [3:0]    sh_w;
  logic [3:0]    sh_m;
  logic [4:0]    wt_cnt;
  logic [4:0]    mb_cnt;
  logic [4:0]    qw;
  logic [4:0]    qm;
  logic          slot_free;
  logic          gnt_dat;
  logic          gnt_wt;
  logic          gnt_wmb;
  logic          gnt_any;
  logic [PW+1:0] gnt_pd;

  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 5'd1;
  endfunction

  assign qw        = {1'b0, sh_w} + 5'd1;
  assign qm        = {1'b0, sh_m} + 5'd1;
  assign slot_free = !out_valid || dma_rd_req_ready;
  assign arb_idle  = !out_valid && !dat_req_valid && !wt_req_valid && !wmb_req_valid;

  // Grant decision. dat only beats a valid weight group once the group has
  // used its quota; inside the group wmb only beats a valid wt once wt has
  // used its quota. Nothing is granted while the output slot is stalled or
  // the block is in reset, which also keeps every ready low in those cycles.
  always_comb begin
    gnt_dat = 1'b0;
    gnt_wt  = 1'b0;
    gnt_wmb = 1'b0;
    if (slot_free && !nvdla_core_rst) begin
      if (dat_req_valid && ((!wt_req_valid && !wmb_req_valid) || (wt_cnt >= qw))) begin
        gnt_dat = 1'b1;
      end else if (wmb_req_valid && (!wt_req_valid || (mb_cnt >= qm))) begin
        gnt_wmb = 1'b1;
      end else if (wt_req_valid) begin
        gnt_wt = 1'b1;
      end
    end
  end

  assign gnt_any       = gnt_dat || gnt_wt || gnt_wmb;
  assign dat_req_ready = gnt_dat;
  assign wt_req_ready  = gnt_wt;
  assign wmb_req_ready = gnt_wmb;

  always_comb begin
    gnt_pd = {SRC_WT, wt_req_pd};
    if (gnt_dat) begin
      gnt_pd = {SRC_DAT, dat_req_pd};
    end else if (gnt_wmb) begin
      gnt_pd = {SRC_WMB, wmb_req_pd};
    end
  end

  // Shadow quotas only follow the registers while the arbiter is idle, so a
  // reprogram during traffic never splits a ratio period halfway.
  // wt_cnt tracks weight-group grants since the last dat grant; mb_cnt tracks
  // wt grants since the last wmb grant.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      sh_w   <= 4'hf;
      sh_m   <= 4'h3;
      wt_cnt <= 5'd0;
      mb_cnt <= 5'd0;
    end else begin
      if (arb_idle) begin
        sh_w <= reg2dp_arb_weight;
        sh_m <= reg2dp_arb_wmb;
      end
      if (gnt_dat) begin
        wt_cnt <= 5'd0;
      end else if (gnt_wmb) begin
        wt_cnt <= sat_inc(wt_cnt);
        mb_cnt <= 5'd0;
      end else if (gnt_wt) begin
        wt_cnt <= sat_inc(wt_cnt);
        mb_cnt <= sat_inc(mb_cnt);
      end
    end
  end

  // Output stage: loads on every grant, drops valid on accept without a new
  // grant, and otherwise holds pd stable for the DMA.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      out_valid <= 1'b0;
      out_pd    <= '0;
    end else if (gnt_any) begin
      out_valid <= 1'b1;
      out_pd    <= gnt_pd;
    end else if (dma_rd_req_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign dma_rd_req_valid = out_valid;
  assign dma_rd_req_pd    = out_pd;

`ifdef NVDLA_CDMA_RD_ARB_PERF_EN
  logic [31:0] perf_dat_q;
  logic [31:0] perf_wt_q;
  logic [31:0] perf_wmb_q;

  // Saturating grant counters, one per source.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      perf_dat_q <= 32'h0;
      perf_wt_q  <= 32'h0;
      perf_wmb_q <= 32'h0;
    end else begin
      if (gnt_dat && (perf_dat_q != 32'hffffffff)) begin
        perf_dat_q <= perf_dat_q + 32'h1;
      end
      if (gnt_wt && (perf_wt_q != 32'hffffffff)) begin
        perf_wt_q <= perf_wt_q + 32'h1;
      end
      if (gnt_wmb && (perf_wmb_q != 32'hffffffff)) begin
        perf_wmb_q <= perf_wmb_q + 32'h1;
      end
    end
  end

  assign perf_dat_cnt = perf_dat_q;
  assign perf_wt_cnt  = perf_wt_q;
  assign perf_wmb_cnt = perf_wmb_q;
`else
  assign perf_dat_cnt = 32'h0;
  assign perf_wt_cnt  = 32'h0;
  assign perf_wmb_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cdma_rd_arb.sv
// -----------------------------------------------------------------------------
// tb_nv_nvdla_cdma_rd_arb
//
// Self-checking bench for nv_nvdla_cdma_rd_arb. Requesters are modelled as
// counters of outstanding requests with sequence-numbered payloads; every
// grant the reference arbitration predicts pushes the expected DMA pd into a
// scoreboard queue that is popped when the DMA accepts.
// -----------------------------------------------------------------------------
module tb_nv_nvdla_cdma_rd_arb;

  localparam int PW = 79;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    reg_w;
  logic [3:0]    reg_m;
  logic          dat_valid, wt_valid, wmb_valid;
  logic          dat_ready, wt_ready, wmb_ready;
  logic [PW-1:0] dat_pd, wt_pd, wmb_pd;
  logic          dma_valid;
  logic          dma_ready;
  logic [PW+1:0] dma_pd;
  logic          arb_idle;
  logic [31:0]   perf_dat, perf_wt, perf_wmb;

  nv_nvdla_cdma_rd_arb #(.PW(PW)) dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rst    (rst),
    .reg2dp_arb_weight (reg_w),
    .reg2dp_arb_wmb    (reg_m),
    .dat_req_valid     (dat_valid),
    .dat_req_ready     (dat_ready),
    .dat_req_pd        (dat_pd),
    .wt_req_valid      (wt_valid),
    .wt_req_ready      (wt_ready),
    .wt_req_pd         (wt_pd),
    .wmb_req_valid     (wmb_valid),
    .wmb_req_ready     (wmb_ready),
    .wmb_req_pd        (wmb_pd),
    .dma_rd_req_valid  (dma_valid),
    .dma_rd_req_ready  (dma_ready),
    .dma_rd_req_pd     (dma_pd),
    .arb_idle          (arb_idle),
    .perf_dat_cnt      (perf_dat),
    .perf_wt_cnt       (perf_wt),
    .perf_wmb_cnt      (perf_wmb)
  );

  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  // Stimulus state: outstanding requests per source, sequence numbers.
  int  rem[3];
  int  seq[3];
  bit  rst_in;
  bit  rdy_in;

  // Reference model state.
  bit            m_valid;
  logic [3:0]    m_sh_w, m_sh_m;
  int            m_wt, m_mb;
  int            gcount[3];
  logic [PW+1:0] sb_q[$];
  int            grant_log[$];

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pd(input int src, input int s);
    logic [7:0]  tag8;
    logic [31:0] s32;
    tag8 = 8'(src + 8'ha0);
    s32  = 32'(s);
    return {39'h0, tag8, s32};
  endfunction

  // One clock cycle: drive at negedge, check combinational/registered outputs
  // 1ns later against the model, then advance the model to the next edge.
  task automatic applyStimulus();
    bit dv, wv, mv, idle, slot;
    int g, qw, qm;
    @(negedge clk);
    dv = rem[0] > 0;
    wv = rem[1] > 0;
    mv = rem[2] > 0;
    rst       = rst_in;
    dma_ready = rdy_in;
    dat_valid = dv;
    wt_valid  = wv;
    wmb_valid = mv;
    dat_pd    = mk_pd(0, seq[0]);
    wt_pd     = mk_pd(1, seq[1]);
    wmb_pd    = mk_pd(2, seq[2]);
    #1;
    idle = !m_valid && !dv && !wv && !mv;
    slot = !m_valid || rdy_in;
    qw = int'(m_sh_w) + 1;
    qm = int'(m_sh_m) + 1;
    g = -1;
    if (!rst_in && slot) begin
      if (dv && ((!wv && !mv) || m_wt >= qw)) g = 0;
      else if (mv && (!wv || m_mb >= qm)) g = 2;
      else if (wv) g = 1;
    end
    checkOutput("dat_ready", dat_ready, g == 0);
    checkOutput("wt_ready", wt_ready, g == 1);
    checkOutput("wmb_ready", wmb_ready, g == 2);
    checkOutput("arb_idle", arb_idle, idle);
    checkOutput("dma_valid", dma_valid, m_valid);
    if (m_valid && sb_q.size() > 0) checkOutput("dma_pd", dma_pd, sb_q[0]);
`ifdef NVDLA_CDMA_RD_ARB_PERF_EN
    checkOutput("perf_dat", perf_dat, gcount[0]);
    checkOutput("perf_wt", perf_wt, gcount[1]);
    checkOutput("perf_wmb", perf_wmb, gcount[2]);
`else
    checkOutput("perf_dat", perf_dat, 0);
    checkOutput("perf_wt", perf_wt, 0);
    checkOutput("perf_wmb", perf_wmb, 0);
`endif
    if (rst_in) begin
      m_valid = 0;
      sb_q.delete();
      m_wt = 0;
      m_mb = 0;
      m_sh_w = 4'hf;
      m_sh_m = 4'h3;
      foreach (gcount[i]) gcount[i] = 0;
    end else begin
      if (m_valid && rdy_in) void'(sb_q.pop_front());
      if (idle) begin
        m_sh_w = reg_w;
        m_sh_m = reg_m;
      end
      if (g >= 0) begin
        sb_q.push_back({2'(g), mk_pd(g, seq[g])});
        m_valid = 1;
        if (g == 0) m_wt = 0;
        else begin
          m_wt = (m_wt >= 16) ? 16 : m_wt + 1;
          if (g == 2) m_mb = 0;
          else m_mb = (m_mb >= 16) ? 16 : m_mb + 1;
        end
        rem[g]--;
        seq[g]++;
        gcount[g]++;
        grant_log.push_back(g);
      end else if (rdy_in) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    foreach (rem[i]) rem[i] = 0;
    rdy_in = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      applyStimulus();
      if (!m_valid) done = 1;
    end
    if (!done) checkOutput("drain_timeout", 1, 0);
    applyStimulus();
  endtask

  task automatic check_alternation(input string tag, input int n);
    if (grant_log.size() < n) checkOutput({tag, "_len"}, grant_log.size(), n);
    else
      for (int i = 0; i + 1 < n; i++) begin
        checkOutput(tag, grant_log[i] + grant_log[i+1], 1);
      end
  endtask

  initial begin
    int exp_pat[17] = '{1,1,1,1,2,1,1,1,1,2,1,1,1,1,2,1,0};
    int first_dat;
    foreach (rem[i]) begin rem[i] = 0; seq[i] = 0; gcount[i] = 0; end
    reg_w = 4'hf;
    reg_m = 4'h3;
    rdy_in = 1;
    rst_in = 0;
    rst = 1;
    dma_ready = 1;
    dat_valid = 0; wt_valid = 0; wmb_valid = 0;
    dat_pd = '0; wt_pd = '0; wmb_pd = '0;
    m_valid = 0; m_sh_w = 4'hf; m_sh_m = 4'h3; m_wt = 0; m_mb = 0;
    repeat (2) @(posedge clk);

    // Reset state, then default quotas with all three sources busy.
    applyStimulus();
    $display("[TB] default quotas, all sources valid");
    grant_log.delete();
    rem[0] = 1000; rem[1] = 1000; rem[2] = 1000;
    repeat (40) applyStimulus();
    for (int i = 0; i < 17; i++) checkOutput("pattern_default", grant_log[i], exp_pat[i]);
    drain();

    // Qw = 1, Qm = 1 loaded while idle: dat and wt alternate every cycle.
    $display("[TB] minimum quotas, dat/wt alternation");
    reg_w = 4'h0; reg_m = 4'h0;
    repeat (2) applyStimulus();
    grant_log.delete();
    rem[0] = 20; rem[1] = 20;
    repeat (10) applyStimulus();
    checkOutput("one_grant_per_cycle", grant_log.size(), 10);
    check_alternation("alternate", 10);
    drain();

    // Dat only, five requests.
    $display("[TB] dat only burst");
    grant_log.delete();
    rem[0] = 5;
    repeat (8) applyStimulus();
    checkOutput("dat_burst_len", grant_log.size(), 5);
    foreach (grant_log[i]) checkOutput("dat_burst_src", grant_log[i], 0);
    checkOutput("idle_after_burst", arb_idle, 1);

    // DMA stall with all sources valid.
    $display("[TB] dma stall");
    rem[0] = 100; rem[1] = 100; rem[2] = 100;
    repeat (2) applyStimulus();
    grant_log.delete();
    rdy_in = 0;
    repeat (4) applyStimulus();
    checkOutput("stall_no_grant", grant_log.size(), 0);
    rdy_in = 1;
    repeat (6) applyStimulus();
    drain();

    // Reprogram weight mid-traffic: old ratio until idle, then Qw = 3.
    $display("[TB] weight change during traffic");
    rem[0] = 100; rem[1] = 100;
    repeat (2) applyStimulus();
    reg_w = 4'h2;
    grant_log.delete();
    repeat (8) applyStimulus();
    check_alternation("old_ratio", 8);
    drain();
    grant_log.delete();
    rem[0] = 100; rem[1] = 100;
    repeat (16) applyStimulus();
    first_dat = -1;
    foreach (grant_log[i]) if (first_dat < 0 && grant_log[i] == 0) first_dat = i;
    if (first_dat < 0 || first_dat + 4 >= grant_log.size()) checkOutput("new_ratio_found", 0, 1);
    else begin
      for (int i = 1; i <= 3; i++) checkOutput("new_ratio_wt", grant_log[first_dat+i], 1);
      checkOutput("new_ratio_dat", grant_log[first_dat+4], 0);
    end

    // Reset pulse while a request is held on the output.
    $display("[TB] reset mid-transfer");
    rem[2] = 100;
    repeat (3) applyStimulus();
    rst_in = 1;
    applyStimulus();
    rst_in = 0;
    applyStimulus();
    repeat (10) applyStimulus();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
